// File: rtl/read_pointer_empty_if.sv
// Read-side pointer bundle: read request and synchronised write pointer in,
// RAM address, Gray read pointer and FIFO status out.
interface read_pointer_empty_if #(
  parameter int address_size = 3
);
  logic                    read_increment;
  logic [address_size:0]   read_to_write_pointer;
  logic [address_size-1:0] read_address;
  logic [address_size:0]   read_pointer;
  logic                    read_empty;
  logic                    read_almost_empty;
  logic [address_size:0]   read_level;
  logic                    read_underflow;

  modport master (
    output read_increment,
    output read_to_write_pointer,
    input  read_address,
    input  read_pointer,
    input  read_empty,
    input  read_almost_empty,
    input  read_level,
    input  read_underflow
  );

  modport slave (
    input  read_increment,
    input  read_to_write_pointer,
    output read_address,
    output read_pointer,
    output read_empty,
    output read_almost_empty,
    output read_level,
    output read_underflow
  );
endinterface

// File: rtl/read_pointer_empty.sv
// Async FIFO read side: binary/Gray read pointer, empty, almost-empty,
// fill level and underflow, all in the read clock domain.
module read_pointer_empty #(
  parameter int address_size           = 3,
  parameter int almost_empty_threshold = 1
) (
  input  logic                 read_clk,
  input  logic                 read_reset_n,
  read_pointer_empty_if.slave  rif
);
  localparam int PW = address_size + 1;
  localparam logic [PW-1:0] AE_TH = PW'(almost_empty_threshold);

  logic [PW-1:0] bin_q, bin_d;
  logic [PW-1:0] gray_q, gray_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] wr_bin;
  logic          empty_q, empty_d;
  logic          aempty_q, aempty_d;
  logic          uflow_q, uflow_d;
  logic          accept;

  always_comb begin
    wr_bin = '0;
    for (int i = 0; i < PW; i++) begin
      wr_bin[i] = ^(rif.read_to_write_pointer >> i);
    end
  end

  // Flags are computed against the post-read pointer so a read and a
  // newly arrived write in the same cycle resolve without extra latency.
  always_comb begin
    accept   = rif.read_increment & ~empty_q;
    bin_d    = bin_q + {{(PW-1){1'b0}}, accept};
    gray_d   = (bin_d >> 1) ^ bin_d;
    level_d  = wr_bin - bin_d;
    empty_d  = (gray_d == rif.read_to_write_pointer);
    aempty_d = (level_d <= AE_TH);
    uflow_d  = rif.read_increment & empty_q;
  end

  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      bin_q    <= '0;
      gray_q   <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      uflow_q  <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      gray_q   <= gray_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      uflow_q  <= uflow_d;
    end
  end

  assign rif.read_address      = bin_q[address_size-1:0];
  assign rif.read_pointer      = gray_q;
  assign rif.read_empty        = empty_q;
  assign rif.read_almost_empty = aempty_q;
  assign rif.read_level        = level_q;
  assign rif.read_underflow    = uflow_q;
endmodule

// File: doc/read_pointer_empty.md
Name: read_pointer_empty

Overview:
- Read-side pointer and flag logic for the asynchronous FIFO, clocked entirely in the read domain.
- Keeps the binary read pointer and drives the RAM read address.
- Publishes the Gray-coded read pointer for synchronisation into the write domain.
- Derives empty, almost-empty, fill level and underflow from the write pointer after it has been synchronised into the read domain.
- Counterpart to the write-to-read pointer synchroniser: it consumes that block's output and produces the pointer that crosses back to the writer.

Parameters:
- address_size, 3, RAM address width; FIFO depth = 2**address_size; pointers are address_size+1 bits.
- almost_empty_threshold, 1, read_almost_empty asserts when the fill level is <= this value.

Ports:
- read_clk  input  1  read-domain clock, rising edge.
- read_reset_n  input  1  asynchronous active-low reset.
- read_increment  input  1  read request; consumes one word when FIFO not empty.
- read_to_write_pointer  input  address_size+1  write pointer, Gray-coded, already synchronised into read domain.
- read_address  output  address_size  RAM read address (low bits of the binary read pointer).
- read_pointer  output  address_size+1  Gray-coded read pointer, registered, to the read-to-write synchroniser.
- read_empty  output  1  FIFO empty, registered.
- read_almost_empty  output  1  level <= almost_empty_threshold, registered.
- read_level  output  address_size+1  words available as seen from the read domain, registered.
- read_underflow  output  1  one-cycle pulse on a read attempted while empty.

Behaviour:
- Reset (read_reset_n low, asynchronous):
  - Binary pointer = 0, read_pointer = 0, read_address = 0, read_level = 0.
  - read_empty = 1, read_almost_empty = 1, read_underflow = 0.
- Accept rule: accept = read_increment & ~read_empty, using the registered read_empty of the current cycle.
- Pointer arithmetic:
  - binary_next = binary + accept, modulo 2**(address_size+1).
  - The MSB wraps and toggles at each full pass.
  - gray_next = (binary_next >> 1) ^ binary_next.
- Register update on each read_clk rising edge:
  - binary <= binary_next.
  - read_pointer <= gray_next.
  - read_address = binary[address_size-1:0], so the address follows the registered binary pointer.
  - Data for an accepted read is the word at read_address in the cycle read_increment is sampled.
- Empty:
  - read_empty <= (gray_next == read_to_write_pointer), a full-width compare including the MSB.
  - Empty therefore reflects the post-read pointer on the same edge that advances it; there is no extra cycle of latency.
- Level:
  - write_binary = Gray-to-binary of read_to_write_pointer (combinational XOR prefix from the MSB down).
  - read_level <= write_binary - binary_next, modulo 2**(address_size+1). Range 0..2**address_size.
- Almost empty: read_almost_empty <= ((write_binary - binary_next) <= almost_empty_threshold).
- Underflow:
  - read_underflow <= read_increment & read_empty.
  - The pointer does not move and no other state changes.
- Simultaneous events: a write-pointer change and a read in the same cycle are resolved by the compare against gray_next. For example, a level of 1 plus a read plus a newly arrived write leaves read_empty = 0 and read_level = 1.
- Synchroniser latency: read_to_write_pointer lags the real write pointer by two read_clk cycles. Empty is therefore pessimistic (it may stay set after a write) and never optimistic.
- Wrap-around: after 2**(address_size+1) reads the pointer returns to 0. Empty/level stay correct because the compare is full width.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronously). Reads pending at that moment are discarded.
- No combinational path from read_increment to any output except read_address, and read_address is combinational only from registered state.

Test Plan (address_size=3, almost_empty_threshold=1):
- Reset, then hold read_to_write_pointer=0 and read_increment=1 for 3 cycles -> read_empty=1, read_pointer=0, read_address=0, read_underflow=1 on each of those cycles.
- Set read_to_write_pointer=Gray(5)=4'b0111 -> the next edge gives read_empty=0, read_level=5, read_almost_empty=0. Five reads then give read_address 0,1,2,3,4. After the 4th read: read_level=1, read_almost_empty=1. After the 5th: read_empty=1, read_pointer=4'b0111.
- Wrap: drive read_to_write_pointer through Gray(8)..Gray(16 mod 16) while reading continuously -> read_address cycles 0..7, 0..7. read_pointer MSB toggles at binary 8. read_empty is set only when pointers match, and read_underflow=0 throughout.
- Simultaneous: at read_level=1, issue a read in the same cycle read_to_write_pointer advances by 1 -> read_empty stays 0, read_level=1.
- Full: read_to_write_pointer=Gray(8)=4'b1100 with binary pointer 0 -> read_level=8, read_empty=0, read_almost_empty=0.
- Assert read_reset_n low mid-burst (binary pointer=3, between clock edges) -> all outputs reach reset values before the next edge. After release, read_empty=1 until the write pointer differs from 0.
